// File: rtl/regfile_arb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_arb_pkg
// Shared constants for the register-file write-back arbiter.
//   NUM_REQ_DEF / ADDR_W_DEF / DATA_W_DEF : default parameter values
//   REQ_ALU / REQ_MEM / REQ_MULDIV         : requester slot indices
// ---------------------------------------------------------------------------
package regfile_arb_pkg;

    localparam int NUM_REQ_DEF = 3;
    localparam int ADDR_W_DEF  = 5;
    localparam int DATA_W_DEF  = 32;

    localparam int REQ_ALU    = 0;
    localparam int REQ_MEM    = 1;
    localparam int REQ_MULDIV = 2;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search. The request vector is rotated so
// that the pointer slot sits at bit 0, the lowest set bit is isolated, and the
// one-hot result is rotated back into requester numbering.
// Ports:
//   valid_i [NUM_REQ] : request vector
//   ptr_i   [PTR_W]   : index at which the search starts (must be < NUM_REQ)
//   en_i              : when low no grant is issued
//   grant_o [NUM_REQ] : one-hot grant (all zero when nothing to grant)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o
);

    logic [NUM_REQ-1:0] rel_valid;
    logic [NUM_REQ-1:0] rel_pick;
    logic [NUM_REQ-1:0] abs_pick;

    // Rotate right by ptr: rel_valid[k] is requester (ptr + k) mod NUM_REQ.
    // A shift by NUM_REQ (ptr = 0) yields zero, so no special case is needed.
    assign rel_valid = (valid_i >> ptr_i) | (valid_i << (NUM_REQ - int'(ptr_i)));

    // Isolate the lowest set bit: the first valid requester at or after ptr.
    assign rel_pick  = rel_valid & (~rel_valid + NUM_REQ'(1));

    // Rotate left by ptr to return to absolute requester numbering.
    assign abs_pick  = (rel_pick << ptr_i) | (rel_pick >> (NUM_REQ - int'(ptr_i)));

    assign grant_o   = en_i ? abs_pick : '0;

endmodule

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Round-robin arbiter merging several write-back requesters onto the single
// register-file write port. One grant per cycle; the granted write appears on
// the register-file port one cycle later. Writes to register 0 are accepted
// but never enabled and are not counted.
// Ports:
//   clock, reset              : clock, synchronous active-high reset
//   req_valid/req_ready       : per-requester handshake
//   req_addr/req_data         : packed per-requester address/data (slice i)
//   hold                      : suspends all grants, freezes the pointer
//   shouldWrite               : register-file write enable
//   writeAddress/writeData    : register-file write address/data
//   write_count               : count of committed non-zero-address writes
// Optional (macro REGFILE_WRITE_ARBITER_BYPASS_EN):
//   bypass_addr_a/_b          : read addresses to forward against
//   bypass_hit_a/_b           : pending write matches a non-zero read address
//   bypass_data_a/_b          : forwarded write data
// ---------------------------------------------------------------------------
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      hold,
    output logic                      shouldWrite,
    output logic [ADDR_W-1:0]         writeAddress,
    output logic [DATA_W-1:0]         writeData,
    output logic [31:0]               write_count
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]         bypass_addr_a,
    input  logic [ADDR_W-1:0]         bypass_addr_b,
    output logic                      bypass_hit_a,
    output logic                      bypass_hit_b,
    output logic [DATA_W-1:0]         bypass_data_a,
    output logic [DATA_W-1:0]         bypass_data_b
`endif
);

    localparam int               PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               should_write_q;
    logic [ADDR_W-1:0]  waddr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [31:0]        count_q;

    logic [NUM_REQ-1:0] grant;
    logic               arb_en;
    logic               xfer;
    logic [PTR_W-1:0]   gidx;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

    // Reset is folded into the enable so no requester sees ready in a reset
    // cycle and therefore never believes it was served.
    assign arb_en = !hold && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .grant_o (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    // Grant is one-hot, so a plain priority scan selects the single winner.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        gidx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
                gidx     = PTR_W'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gidx == LAST_IDX) ? '0 : gidx + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q          <= '0;
            should_write_q <= 1'b0;
            waddr_q        <= '0;
            wdata_q        <= '0;
            count_q        <= '0;
        end else begin
            ptr_q          <= ptr_d;
            should_write_q <= xfer && (sel_addr != '0);
            if (xfer) begin
                waddr_q <= sel_addr;
                wdata_q <= sel_data;
            end
            // Counted alongside the enable so write_count already includes
            // the write being presented on the port.
            if (xfer && (sel_addr != '0)) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    assign shouldWrite  = should_write_q;
    assign writeAddress = waddr_q;
    assign writeData    = wdata_q;
    assign write_count  = count_q;

`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    assign bypass_hit_a  = should_write_q && (waddr_q == bypass_addr_a) && (bypass_addr_a != '0);
    assign bypass_hit_b  = should_write_q && (waddr_q == bypass_addr_b) && (bypass_addr_b != '0);
    assign bypass_data_a = wdata_q;
    assign bypass_data_b = wdata_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic            hold;
    logic            shouldWrite;
    logic [AW-1:0]   writeAddress;
    logic [DW-1:0]   writeData;
    logic [31:0]     write_count;
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
    logic [AW-1:0]   bypass_addr_a, bypass_addr_b;
    logic            bypass_hit_a, bypass_hit_b;
    logic [DW-1:0]   bypass_data_a, bypass_data_b;
`endif

    regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock        (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .hold         (hold),
        .shouldWrite  (shouldWrite),
        .writeAddress (writeAddress),
        .writeData    (writeData),
        .write_count  (write_count)
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
        ,
        .bypass_addr_a (bypass_addr_a),
        .bypass_addr_b (bypass_addr_b),
        .bypass_hit_a  (bypass_hit_a),
        .bypass_hit_b  (bypass_hit_b),
        .bypass_data_a (bypass_data_a),
        .bypass_data_b (bypass_data_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sw;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [31:0]   c;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: requester queues, round-robin pointer, register-file port.
    bit            pend [N];
    logic [AW-1:0] paddr[N];
    logic [DW-1:0] pdata[N];
    int            m_ptr;
    bit            m_sw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [31:0]   m_count;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic post(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!pend[i]) begin
            pend[i]  = 1'b1;
            paddr[i] = a;
            pdata[i] = d;
        end
    endtask

    task automatic step(input bit rst, input bit hld);
        int           g;
        logic [N-1:0] exp_rdy;
        exp_t         e;
        @(negedge clk);
        reset = rst;
        hold  = hld;
        for (int i = 0; i < N; i++) begin
            req_valid[i]           = pend[i];
            req_addr[i*AW +: AW]   = paddr[i];
            req_data[i*DW +: DW]   = pdata[i];
        end
        #1;
        g = -1;
        if (!rst && !hld) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (rst) begin
            m_ptr = 0; m_sw = 1'b0; m_addr = '0; m_data = '0; m_count = '0;
        end else if (g >= 0) begin
            m_ptr  = (g + 1) % N;
            m_addr = paddr[g];
            m_data = pdata[g];
            m_sw   = (paddr[g] != '0);
            if (m_sw) m_count = m_count + 32'd1;
            pend[g] = 1'b0;
        end else begin
            m_sw = 1'b0;
        end
        e.sw = m_sw; e.a = m_addr; e.d = m_data; e.c = m_count;
        q.push_back(e);
    endtask

    // Monitor: the register-file port is presented every cycle after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("shouldWrite",  32'(shouldWrite),  32'(e.sw));
                chk("writeAddress", 32'(writeAddress), 32'(e.a));
                chk("writeData",    writeData,         e.d);
                chk("write_count",  write_count,       e.c);
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
                bypass_addr_a = e.a;
                bypass_addr_b = e.a ^ AW'(1);
                #1;
                chk("bypass_hit_a",  32'(bypass_hit_a), 32'(e.sw && e.a != '0));
                chk("bypass_hit_b",  32'(bypass_hit_b), 32'(0));
                chk("bypass_data_a", bypass_data_a,     e.d);
                chk("bypass_data_b", bypass_data_b,     e.d);
`endif
            end
        end
    end

    initial begin
        reset = 1'b1; hold = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0;
`ifdef REGFILE_WRITE_ARBITER_BYPASS_EN
        bypass_addr_a = '0; bypass_addr_b = '0;
`endif
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; paddr[i] = '0; pdata[i] = '0;
        end
        m_ptr = 0; m_sw = 1'b0; m_addr = '0; m_data = '0; m_count = '0;

        step(1, 0);
        step(1, 0);

        // Single ALU write
        post(0, 5'd5, 32'h1234_5678);
        step(0, 0);
        step(0, 0);

        // All requesters continuously valid from reset
        step(1, 0);
        repeat (6) begin
            post(0, 5'd1, $urandom);
            post(1, 5'd2, $urandom);
            post(2, 5'd3, $urandom);
            step(0, 0);
        end
        repeat (3) step(0, 0);

        // Same-address collision with pointer at MEM
        step(1, 0);
        post(0, 5'd4, 32'h0000_0044);
        step(0, 0);
        post(1, 5'd7, 32'h0000_000A);
        post(2, 5'd7, 32'h0000_000B);
        repeat (3) step(0, 0);

        // Write to register 0
        post(0, 5'd0, 32'hFFFF_FFFF);
        step(0, 0);
        step(0, 0);

        // Hold with everyone valid
        post(0, 5'd11, $urandom);
        post(1, 5'd12, $urandom);
        post(2, 5'd13, $urandom);
        repeat (3) step(0, 1);
        repeat (4) step(0, 0);

        // Write to 9, then reset while ALU valid and that write registered
        post(0, 5'd9, 32'hCAFE_0009);
        step(0, 0);
        post(0, 5'd6, 32'h0000_0066);
        step(1, 0);
        step(0, 0);
        step(0, 0);

        // Randomized traffic
        repeat (1500) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) == 0) post(i, AW'($urandom_range(0, 7)), $urandom);
            end
            step($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0);
        end
        repeat (6) step(0, 0);

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3, number of write-back requesters (index 0 = ALU, 1 = MEM load, 2 = MULDIV).
REQ-002 Parameter ADDR_W, default 5, register address width.
REQ-003 Parameter DATA_W, default 32, register data width.
REQ-004 One clock; reset is synchronous and active-high. Ports are named clock and reset.
REQ-005 clock  input  1  block clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 req_valid  input  NUM_REQ  per-requester write request.
REQ-008 req_ready  output  NUM_REQ  per-requester grant; at most one bit high per cycle.
REQ-009 req_addr  input  NUM_REQ*ADDR_W  packed destination addresses; requester i in slice i.
REQ-010 req_data  input  NUM_REQ*DATA_W  packed write data; requester i in slice i.
REQ-011 hold  input  1  suspends all grants while high.
REQ-012 shouldWrite  output  1  write enable to the register file.
REQ-013 writeAddress  output  ADDR_W  register file write address.
REQ-014 writeData  output  DATA_W  register file write data.
REQ-015 write_count  output  32  count of committed non-zero-address writes.

Function
REQ-016 Transfer on requester i occurs in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-017 Requester holds valid, addr and data stable until its transfer; dropping valid before ready is illegal.
REQ-018 req_ready is combinational from req_valid, hold and the priority pointer. It is never high for a requester with valid low.
REQ-019 Round-robin arbitration: search starts at pointer index and wraps modulo NUM_REQ. The first valid requester found is granted.
REQ-020 After a grant to index g, pointer <= (g+1) mod NUM_REQ. Pointer is unchanged in cycles with no grant.
REQ-021 Latency one cycle: a transfer in cycle N drives shouldWrite/writeAddress/writeData in cycle N+1 with the granted addr/data.
REQ-022 In cycles with no transfer, shouldWrite = 0 next cycle. writeAddress/writeData hold their last values.
REQ-023 A transfer with addr 0 is accepted (ready high) but produces shouldWrite = 0, and write_count does not increment.
REQ-024 write_count increments by 1 per cycle in which shouldWrite is high. It wraps from 0xFFFFFFFF to 0.
REQ-025 While hold is high, req_ready = 0 and the pointer is frozen. A write already registered still issues in the following cycle.
REQ-026 Same-address requests in one cycle are serialized in grant order. The later grant's data is the final register contents.
REQ-027 A single continuously valid requester with all others idle is granted every cycle (full throughput).

Reset
REQ-028 Reset overrides all other inputs in the same edge.
REQ-029 Reset values: shouldWrite 0, writeAddress 0, writeData 0, write_count 0, pointer 0.
REQ-030 req_ready is 0 during any cycle in which reset is high.
REQ-031 A transfer presented in the same cycle as reset is discarded, and the requester is not considered served.

Configuration
REQ-032 Macro REGFILE_WRITE_ARBITER_BYPASS_EN compiles in a forwarding port.
- Adds inputs bypass_addr_a and bypass_addr_b (ADDR_W each).
- Adds outputs bypass_hit_a and bypass_hit_b (1 each), and bypass_data_a and bypass_data_b (DATA_W each).
REQ-033 With the macro defined: bypass_hit_x = shouldWrite && writeAddress == bypass_addr_x && bypass_addr_x != 0, and bypass_data_x = writeData. Both are combinational.
REQ-034 Without the macro, these ports and their logic are absent. All other behaviour is identical.

Structure
REQ-035 Shared package regfile_arb_pkg holds:
- NUM_REQ, ADDR_W and DATA_W defaults;
- requester index constants REQ_ALU = 0, REQ_MEM = 1, REQ_MULDIV = 2.
REQ-036 Sub-module rr_arbiter (inputs: valid vector, pointer, enable; output: one-hot grant) contains the round-robin search. The top level contains the pointer, output registers and counter.

Verification
REQ-037 Single ALU request, addr 5, data 0x12345678 -> ready same cycle; next cycle shouldWrite = 1, writeAddress = 5, writeData = 0x12345678, write_count = 1.
REQ-038 All three valid continuously from reset with addrs 1/2/3 -> grants in order 0, 1, 2, 0, 1, 2; exactly one ready per cycle.
REQ-039 MEM and MULDIV both target addr 7 with data 0xA and 0xB, pointer at 1 -> MEM granted first, MULDIV next cycle; final write is addr 7 = 0xB.
REQ-040 Request with addr 0, data 0xFFFFFFFF -> ready high; next cycle shouldWrite = 0; write_count unchanged.
REQ-041 hold raised for 3 cycles with all requesters valid -> ready = 0 for those 3 cycles; pointer unchanged; arbitration resumes at the same index after hold drops.
REQ-042 reset asserted while ALU is valid and a write is registered -> next cycle all outputs are 0 and pointer is 0. With REGFILE_WRITE_ARBITER_BYPASS_EN: writeAddress = 9 and bypass_addr_a = 9 -> bypass_hit_a = 1.
